ha_rr_arbiter: RTL and testbench
================================

HA_RR_ARBITER -- requirements
Module: ha_rr_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one halfAdder (2..8).
REQ-002 Port: clk  in  1  single clock; all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid_in  in  NUM_REQ  per-requester operand valid.
REQ-005 Port: req_a_in  in  NUM_REQ  per-requester operand a (bit i = requester i).
REQ-006 Port: req_b_in  in  NUM_REQ  per-requester operand b.
REQ-007 Port: req_ready_out  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 Port: rsp_valid_out  out  NUM_REQ  one-hot result valid to the granted requester.
REQ-009 Port: rsp_sum_out  out  1  shared result sum.
REQ-010 Port: rsp_carry_out  out  1  shared result carry.
REQ-011 Port: rsp_ready_in  in  NUM_REQ  per-requester result accept.
REQ-012 Port: add_a_out, add_b_out  out  1 each  operands to halfAdder a_in/b_in.
REQ-013 Port: add_valid_out  out  1  to halfAdder valid_in.
REQ-014 Port: add_ready_in  in  1  from halfAdder ready_out.
REQ-015 Port: add_sum_in, add_carry_in, add_valid_in  in  1 each  from halfAdder sum_out/carry_out/valid_out.
REQ-016 Port: add_ready_out  out  1  to halfAdder ready_in.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-018 IDLE: winner = first requester with req_valid_in high, searching from (last_grant+1) mod NUM_REQ upward with wrap; req_ready_out[winner]=1 combinationally in the same cycle.
REQ-019 IDLE handshake (valid & ready on winner): latch a, b, grant index g; next state ISSUE. No valid inputs: remain IDLE, all req_ready_out=0.
REQ-020 ISSUE: add_valid_out=1, add_a_out/add_b_out = latched operands, stable until add_ready_in=1; on that edge -> WAIT.
REQ-021 WAIT: add_ready_out=1; on add_valid_in=1 latch add_sum_in/add_carry_in, -> RESP. add_ready_out=0 in all other states.
REQ-022 RESP: rsp_valid_out[g]=1, sum/carry held stable; on rsp_ready_in[g]=1 set last_grant=g, -> IDLE.
REQ-023 rsp_ready_in bits other than g are ignored; rsp_sum_out/rsp_carry_out keep the last result when rsp_valid_out=0.
REQ-024 Minimum latency: 4 cycles from request accept to next IDLE (one cycle per state when downstream is always ready).
REQ-025 Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
REQ-026 A requester dropping req_valid_in before acceptance loses nothing; arbitration re-evaluates each IDLE cycle.
REQ-027 add_valid_in outside WAIT is ignored and does not change state.

Reset
REQ-028 On rst: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), latched operands/results=0.
REQ-029 During and after rst: req_ready_out=0 (until IDLE evaluation), rsp_valid_out=0, add_valid_out=0, add_ready_out=0, all data outputs 0.
REQ-030 rst mid-transaction abandons it; no response is issued for it; the halfAdder is reset by the same rst.

Structure
REQ-031 Shared package ha_arb_pkg holds the FSM state typedef, NUM_REQ default, and grant-index width constant ($clog2(NUM_REQ)).
REQ-032 One sub-module rr_pick: combinational round-robin selector (request vector, last_grant -> one-hot grant, index, any).
REQ-033 halfAdder is instantiated outside this block; arbiter connects only through the add_* ports.

Verification
REQ-034 Single request: req 2 valid, a=1,b=1 -> ready_out[2] pulse, add_a/b=1/1, rsp_valid_out=0100, sum=0, carry=1.
REQ-035 All four valid continuously, distinct operands -> grant order 0,1,2,3,0, each result matching a XOR b / a AND b.
REQ-036 Backpressure: add_ready_in low 3 cycles in ISSUE, rsp_ready_in low 5 cycles in RESP -> outputs stable, no new req_ready_out.
REQ-037 Wrap-around: last_grant=3, requests on 1 and 3 -> requester 1 granted next, then 3.
REQ-038 rst asserted in WAIT -> next cycle all outputs 0, state IDLE; subsequent request 0 served correctly.
REQ-039 Stray add_valid_in=1 in IDLE and wrong-index rsp_ready_in in RESP -> no state change, no lost or duplicated response.

Source files
------------

// File: rtl/ha_arb_pkg.sv
// Shared types and constants for the round-robin halfAdder arbiter.
// Holds FSM state encoding, default requester count and grant-index width.
package ha_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int GRANT_W         = $clog2(NUM_REQ_DEFAULT);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef struct packed {
    logic a;
    logic b;
  } operand_t;

  typedef struct packed {
    logic sum;
    logic carry;
  } result_t;

  // Index width for an arbitrary requester count, never narrower than 1 bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ha_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from last_i+1 with wrap.
// Zero latency; no state, so no backpressure of its own.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any_o && req_i[W'((int'(last_i) + i) % N)]) begin
        any_o                                = 1'b1;
        gnt_idx_o                            = W'((int'(last_i) + i) % N);
        gnt_oh_o[W'((int'(last_i) + i) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ha_rr_arbiter.sv
// Round-robin arbiter sharing one halfAdder among NUM_REQ requesters, one op in flight.
// Minimum 4 cycles accept-to-IDLE; stalls in ISSUE on add_ready_in, in RESP on rsp_ready_in[g].
module ha_rr_arbiter
  import ha_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_in,
  input  logic [NUM_REQ-1:0] req_a_in,
  input  logic [NUM_REQ-1:0] req_b_in,
  output logic [NUM_REQ-1:0] req_ready_out,
  output logic [NUM_REQ-1:0] rsp_valid_out,
  output logic               rsp_sum_out,
  output logic               rsp_carry_out,
  input  logic [NUM_REQ-1:0] rsp_ready_in,
  output logic               add_a_out,
  output logic               add_b_out,
  output logic               add_valid_out,
  input  logic               add_ready_in,
  input  logic               add_sum_in,
  input  logic               add_carry_in,
  input  logic               add_valid_in,
  output logic               add_ready_out
);

  localparam int IDX_W = grant_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  operand_t           opnd_q, opnd_d;
  result_t            res_q, res_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               active;

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_rr_pick (
    .req_i     (req_valid_in),
    .last_i    (last_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        // The winner is already valid, so presenting ready completes the handshake.
        if (pick_any) begin
          opnd_d.a = req_a_in[pick_idx];
          opnd_d.b = req_b_in[pick_idx];
          gnt_d    = pick_idx;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (add_ready_in) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_valid_in) begin
          res_d.sum   = add_sum_in;
          res_d.carry = add_carry_in;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_in[gnt_q]) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  // Outputs are forced quiet while rst is high, before the registers have settled.
  assign active = !rst;

  always_comb begin
    req_ready_out = (active && state_q == ST_IDLE) ? pick_oh : '0;
    rsp_valid_out = (active && state_q == ST_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    add_valid_out = active && (state_q == ST_ISSUE);
    add_ready_out = active && (state_q == ST_WAIT);
    add_a_out     = active && opnd_q.a;
    add_b_out     = active && opnd_q.b;
    rsp_sum_out   = active && res_q.sum;
    rsp_carry_out = active && res_q.carry;
  end

endmodule

// File: tb/tb_ha_rr_arbiter.sv
// Randomized and directed bench for ha_rr_arbiter; the bench plays requesters and halfAdder.
// A round-robin reference model predicts grants and results from operand arithmetic.
module tb_ha_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid_in, req_a_in, req_b_in, req_ready_out;
  logic [N-1:0] rsp_valid_out, rsp_ready_in;
  logic         rsp_sum_out, rsp_carry_out;
  logic         add_a_out, add_b_out, add_valid_out, add_ready_in;
  logic         add_sum_in, add_carry_in, add_valid_in, add_ready_out;

  int   vectors = 0;
  int   miscompares = 0;
  int   ref_last;
  logic ref_sum, ref_carry;
  int   w;

  always #5 clk = ~clk;

  ha_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_in  (req_valid_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .req_ready_out (req_ready_out),
    .rsp_valid_out (rsp_valid_out),
    .rsp_sum_out   (rsp_sum_out),
    .rsp_carry_out (rsp_carry_out),
    .rsp_ready_in  (rsp_ready_in),
    .add_a_out     (add_a_out),
    .add_b_out     (add_b_out),
    .add_valid_out (add_valid_out),
    .add_ready_in  (add_ready_in),
    .add_sum_in    (add_sum_in),
    .add_carry_in  (add_carry_in),
    .add_valid_in  (add_valid_in),
    .add_ready_out (add_ready_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  // Reference grant: first valid requester after the last one served, wrapping.
  function automatic int rr_winner(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string t);
    chk({t, "_rspv"}, 32'(rsp_valid_out), 32'(0));
    chk({t, "_addv"}, 32'(add_valid_out), 32'(0));
    chk({t, "_addr"}, 32'(add_ready_out), 32'(0));
    chk({t, "_sum"},  32'(rsp_sum_out),   32'(ref_sum));
    chk({t, "_cry"},  32'(rsp_carry_out), 32'(ref_carry));
  endtask

  task automatic xact(input logic [N-1:0] mask, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input int st_iss, input int st_wait, input int st_resp,
                      input bit stray, input bit abort, output int win);
    logic ea, eb;
    req_valid_in = mask;
    req_a_in     = av;
    req_b_in     = bv;
    rsp_ready_in = '0;
    add_ready_in = 1'b0;
    add_valid_in = 1'b0;
    #1;
    win = rr_winner(mask, ref_last);
    ea  = av[win];
    eb  = bv[win];
    chk("idle_ready", 32'(req_ready_out), 32'(onehot(win)));
    idle_checks("idle");
    tick;
    for (int s = 0; s <= st_iss; s++) begin
      add_ready_in = (s == st_iss);
      add_valid_in = stray && (s != st_iss);
      #1;
      chk("iss_addv",  32'(add_valid_out), 32'(1));
      chk("iss_a",     32'(add_a_out),     32'(ea));
      chk("iss_b",     32'(add_b_out),     32'(eb));
      chk("iss_ready", 32'(req_ready_out), 32'(0));
      chk("iss_addr",  32'(add_ready_out), 32'(0));
      tick;
    end
    add_ready_in = 1'b0;
    add_valid_in = 1'b0;
    for (int s = 0; s <= st_wait; s++) begin
      if (abort && s == st_wait) begin
        rst = 1'b1;
        #1;
        chk("rst_addr", 32'(add_ready_out), 32'(0));
        tick;
        chk("rst_rspv", 32'(rsp_valid_out), 32'(0));
        chk("rst_addv", 32'(add_valid_out), 32'(0));
        chk("rst_a",    32'(add_a_out),     32'(0));
        chk("rst_sum",  32'(rsp_sum_out),   32'(0));
        chk("rst_cry",  32'(rsp_carry_out), 32'(0));
        rst          = 1'b0;
        req_valid_in = '0;
        ref_last     = N - 1;
        ref_sum      = 1'b0;
        ref_carry    = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready_out), 32'(0));
        idle_checks("post_rst");
        return;
      end
      add_valid_in = (s == st_wait);
      add_sum_in   = (s == st_wait) ? (ea ^ eb) : 1'($urandom);
      add_carry_in = (s == st_wait) ? (ea & eb) : 1'($urandom);
      #1;
      chk("wait_addr",  32'(add_ready_out), 32'(1));
      chk("wait_addv",  32'(add_valid_out), 32'(0));
      chk("wait_ready", 32'(req_ready_out), 32'(0));
      tick;
    end
    add_valid_in = 1'b0;
    for (int s = 0; s <= st_resp; s++) begin
      rsp_ready_in = (s == st_resp) ? onehot(win) : (stray ? (~onehot(win) & N'($urandom)) : '0);
      add_valid_in = stray;
      add_sum_in   = 1'($urandom);
      add_carry_in = 1'($urandom);
      #1;
      chk("resp_valid", 32'(rsp_valid_out), 32'(onehot(win)));
      chk("resp_sum",   32'(rsp_sum_out),   32'(ea ^ eb));
      chk("resp_cry",   32'(rsp_carry_out), 32'(ea & eb));
      chk("resp_ready", 32'(req_ready_out), 32'(0));
      chk("resp_addr",  32'(add_ready_out), 32'(0));
      tick;
    end
    rsp_ready_in = '0;
    add_valid_in = 1'b0;
    ref_last     = win;
    ref_sum      = ea ^ eb;
    ref_carry    = ea & eb;
  endtask

  task automatic idle_stray;
    req_valid_in = '0;
    add_valid_in = 1'b1;
    add_sum_in   = ~ref_sum;
    add_carry_in = ~ref_carry;
    #1;
    chk("stray_ready", 32'(req_ready_out), 32'(0));
    idle_checks("stray_idle");
    tick;
    add_valid_in = 1'b0;
    #1;
    chk("stray_ready2", 32'(req_ready_out), 32'(0));
    idle_checks("stray_idle2");
  endtask

  initial begin
    logic [N-1:0] fa [5];
    logic [N-1:0] fb [5];
    fa = '{4'b1010, 4'b0110, 4'b1111, 4'b0001, 4'b1100};
    fb = '{4'b0110, 4'b1010, 4'b0000, 4'b1101, 4'b0101};

    rst          = 1'b1;
    req_valid_in = '1;
    req_a_in     = '1;
    req_b_in     = '1;
    rsp_ready_in = '1;
    add_ready_in = 1'b1;
    add_valid_in = 1'b1;
    add_sum_in   = 1'b1;
    add_carry_in = 1'b1;
    #1;
    chk("in_rst_ready", 32'(req_ready_out), 32'(0));
    tick;
    tick;
    chk("rst_ready", 32'(req_ready_out), 32'(0));
    chk("rst_rspv",  32'(rsp_valid_out), 32'(0));
    chk("rst_addv",  32'(add_valid_out), 32'(0));
    chk("rst_addr",  32'(add_ready_out), 32'(0));
    chk("rst_b",     32'(add_b_out),     32'(0));
    chk("rst_sum",   32'(rsp_sum_out),   32'(0));
    rst          = 1'b0;
    req_valid_in = '0;
    rsp_ready_in = '0;
    add_ready_in = 1'b0;
    add_valid_in = 1'b0;
    ref_last     = N - 1;
    ref_sum      = 1'b0;
    ref_carry    = 1'b0;
    #1;
    chk("idle_no_req", 32'(req_ready_out), 32'(0));
    idle_checks("reset_idle");

    // Single request on 2 with a=b=1: sum 0, carry 1.
    xact(4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 1'b0, 1'b0, w);
    // Bring last grant to 3, then all four continuously valid: 0,1,2,3,0.
    xact(4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 1'b0, 1'b0, w);
    for (int i = 0; i < 5; i++)
      xact(4'b1111, fa[i], fb[i], 0, 0, 0, 1'b0, 1'b0, w);
    // Backpressure with other requesters waiting, plus stray handshakes.
    xact(4'b1111, 4'b0011, 4'b0101, 3, 1, 5, 1'b1, 1'b0, w);
    // Wrap-around from last grant 3 with requests on 1 and 3.
    xact(4'b1000, 4'b0000, 4'b1000, 0, 0, 0, 1'b0, 1'b0, w);
    xact(4'b1010, 4'b1010, 4'b0010, 0, 0, 0, 1'b0, 1'b0, w);
    xact(4'b1010, 4'b1000, 4'b1000, 0, 0, 0, 1'b0, 1'b0, w);
    idle_stray();
    // Abort in WAIT, then confirm requester 0 wins and is served.
    xact(4'b0110, 4'b0110, 4'b0110, 1, 2, 0, 1'b0, 1'b1, w);
    xact(4'b1111, 4'b0001, 4'b0001, 0, 0, 0, 1'b0, 1'b0, w);

    for (int n = 0; n < 60; n++) begin
      logic [N-1:0] m;
      m = N'($urandom);
      if (m == '0) begin
        idle_stray();
      end else begin
        xact(m, N'($urandom), N'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 15) == 0), w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
